// File: rtl/sram_like_arbiter_pkg.sv
// Shared widths, owner IDs and lock states for the SRAM-like inst/data arbiter.
package sram_like_arbiter_pkg;

    localparam int SIZE_W  = 2;
    localparam int WSTRB_W = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    typedef enum logic {
        ARB_ID_INST = 1'b0,
        ARB_ID_DATA = 1'b1
    } arb_id_t;

    typedef enum logic {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_t;

    // Fixed-priority pick among the currently asserting requesters.
    function automatic arb_id_t pick_grant(input logic m0_req, input logic m1_req,
                                           input logic data_prio);
        arb_id_t id;
        id = ARB_ID_INST;
        if (m0_req && m1_req) begin
            id = data_prio ? ARB_ID_DATA : ARB_ID_INST;
        end else if (m1_req) begin
            id = ARB_ID_DATA;
        end
        return id;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response bundle: master drives the request, slave answers addr_ok/data_ok.
interface sram_like_arbiter_if;
    import sram_like_arbiter_pkg::*;

    logic               req;
    logic               wr;
    logic [SIZE_W-1:0]  size;
    logic [WSTRB_W-1:0] wstrb;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               addr_ok;
    logic               data_ok;
    logic [DATA_W-1:0]  rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_arbiter_arb_id_fifo.sv
// Owner-ID FIFO: 1-bit entries, DEPTH deep (power of 2), registered full/empty/count.
// Callers must not push while full; simultaneous push and pop keep the count unchanged.
module arb_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  arb_id_t                push_id,
    input  logic                   pop,
    output arb_id_t                head_id,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = arb_id_t'(mem[rptr]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_id;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave between inst (m0) and data (m1) masters; requests pass through
// combinationally and in-order responses are steered back using a FIFO of owner IDs.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    sram_like_arbiter_if.slave         m0,
    sram_like_arbiter_if.slave         m1,
    sram_like_arbiter_if.master        s,
    output logic [$clog2(MAX_OUTST):0] outst_cnt,
    output logic                       err_unexp_rsp
);

    lock_state_t lock_st;
    arb_id_t     lock_id;
    arb_id_t     grant;
    arb_id_t     head_id;
    logic        fifo_full;
    logic        fifo_empty;
    logic        s_req;
    logic        accept;
    logic        rsp;

    // A pending unaccepted request pins the grant so fields never change under the slave.
    always_comb begin
        grant = pick_grant(m0.req, m1.req, DATA_PRIO);
        if (lock_st == LK_LOCKED) begin
            grant = lock_id;
        end
    end

    assign s_req   = (m0.req || m1.req) && !fifo_full;
    assign accept  = s_req && s.addr_ok;
    assign rsp     = s.data_ok && !fifo_empty;

    assign s.req   = s_req;
    assign s.wr    = (grant == ARB_ID_DATA) ? m1.wr    : m0.wr;
    assign s.size  = (grant == ARB_ID_DATA) ? m1.size  : m0.size;
    assign s.wstrb = (grant == ARB_ID_DATA) ? m1.wstrb : m0.wstrb;
    assign s.addr  = (grant == ARB_ID_DATA) ? m1.addr  : m0.addr;
    assign s.wdata = (grant == ARB_ID_DATA) ? m1.wdata : m0.wdata;

    assign m0.addr_ok = accept && (grant == ARB_ID_INST);
    assign m1.addr_ok = accept && (grant == ARB_ID_DATA);

    assign m0.data_ok = rsp && (head_id == ARB_ID_INST);
    assign m1.data_ok = rsp && (head_id == ARB_ID_DATA);
    assign m0.rdata   = m0.data_ok ? s.rdata : '0;
    assign m1.rdata   = m1.data_ok ? s.rdata : '0;

    arb_id_fifo #(
        .DEPTH   (MAX_OUTST)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (grant),
        .pop     (rsp),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outst_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_st <= LK_IDLE;
            lock_id <= ARB_ID_INST;
        end else begin
            case (lock_st)
                LK_IDLE: begin
                    if (s_req && !s.addr_ok) begin
                        lock_st <= LK_LOCKED;
                        lock_id <= grant;
                    end
                end
                LK_LOCKED: begin
                    if (s.addr_ok) begin
                        lock_st <= LK_IDLE;
                    end
                end
                default: lock_st <= LK_IDLE;
            endcase
        end
    end

    // A response with an empty FIFO (including one racing a same-cycle accept) is a slave fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_unexp_rsp <= 1'b0;
        end else if (s.data_ok && fifo_empty) begin
            err_unexp_rsp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (MAX_OUTST=4, DATA_PRIO=1): inputs change and outputs
// are sampled just after the falling edge; state updates land on the following rising edge.
module tb_sram_like_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] outst_cnt;
    logic       err_unexp_rsp;
    int         n_cmp = 0;
    int         n_mis = 0;

    sram_like_arbiter_if m0_if ();
    sram_like_arbiter_if m1_if ();
    sram_like_arbiter_if s_if ();

    sram_like_arbiter #(
        .MAX_OUTST     (4),
        .DATA_PRIO     (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m0            (m0_if),
        .m1            (m1_if),
        .s             (s_if),
        .outst_cnt     (outst_cnt),
        .err_unexp_rsp (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        m0_if.req = 0; m0_if.wr = 0; m0_if.size = 2'd2; m0_if.wstrb = 4'h0;
        m0_if.addr = 32'h0000_1000; m0_if.wdata = 32'h0;
        m1_if.req = 0; m1_if.wr = 0; m1_if.size = 2'd2; m1_if.wstrb = 4'h0;
        m1_if.addr = 32'h0000_2000; m1_if.wdata = 32'h0;
        s_if.addr_ok = 0; s_if.data_ok = 0; s_if.rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        m0_if.req = 1; m1_if.req = 1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (outst_cnt !== 3'd0) begin n_mis++; $display("FAIL rst_cnt: got %0d want 0", outst_cnt); end
        n_cmp++; if (err_unexp_rsp !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b want 0", err_unexp_rsp); end
        n_cmp++; if (s_if.req !== 1'b1) begin n_mis++; $display("FAIL rst_s_req: got %b want 1", s_if.req); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (s_if.addr !== 32'h0000_2000) begin n_mis++; $display("FAIL rst_s_addr: got %h want 00002000", s_if.addr); end
        n_cmp++; if ({m0_if.addr_ok, m1_if.addr_ok} !== 2'b00) begin n_mis++; $display("FAIL rst_addr_ok: got %b want 00", {m0_if.addr_ok, m1_if.addr_ok}); end
        @(negedge clk); #1;
        n_cmp++; if (s_if.addr !== 32'h0000_2000) begin n_mis++; $display("FAIL rst_lock_m1: got %h want 00002000", s_if.addr); end
    endtask

    task automatic test_lock();
        do_reset();
        @(negedge clk);
        m0_if.req = 1; m0_if.addr = 32'h0000_0100;
        #1;
        n_cmp++; if (s_if.addr !== 32'h0000_0100) begin n_mis++; $display("FAIL lock_c1_addr: got %h want 00000100", s_if.addr); end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            m1_if.req = 1; m1_if.addr = 32'h0000_0200;
            #1;
            n_cmp++; if (s_if.addr !== 32'h0000_0100) begin n_mis++; $display("FAIL lock_c%0d_addr: got %h want 00000100", c, s_if.addr); end
        end
        @(negedge clk);
        s_if.addr_ok = 1;
        #1;
        n_cmp++; if ({m0_if.addr_ok, m1_if.addr_ok} !== 2'b10) begin n_mis++; $display("FAIL lock_c4_addr_ok: got %b want 10", {m0_if.addr_ok, m1_if.addr_ok}); end
        @(negedge clk); #1;
        n_cmp++; if (s_if.addr !== 32'h0000_0200) begin n_mis++; $display("FAIL lock_c5_addr: got %h want 00000200", s_if.addr); end
        n_cmp++; if ({m0_if.addr_ok, m1_if.addr_ok} !== 2'b01) begin n_mis++; $display("FAIL lock_c5_addr_ok: got %b want 01", {m0_if.addr_ok, m1_if.addr_ok}); end
        n_cmp++; if (outst_cnt !== 3'd1) begin n_mis++; $display("FAIL lock_c5_cnt: got %0d want 1", outst_cnt); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (outst_cnt !== 3'd2) begin n_mis++; $display("FAIL lock_c6_cnt: got %0d want 2", outst_cnt); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] rd [4];
        logic        exp_id [4];
        rd = '{32'h11, 32'h22, 32'h33, 32'h44};
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i % 2 == 1) m1_if.req = 1; else m0_if.req = 1;
            s_if.addr_ok = 1;
            #1;
            n_cmp++; if (outst_cnt !== 3'(i)) begin n_mis++; $display("FAIL fill_cnt%0d: got %0d want %0d", i, outst_cnt, i); end
            n_cmp++; if ({m0_if.addr_ok, m1_if.addr_ok} !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin n_mis++; $display("FAIL fill_addr_ok%0d: got %b", i, {m0_if.addr_ok, m1_if.addr_ok}); end
        end
        @(negedge clk);
        m0_if.req = 1; m1_if.req = 1; s_if.addr_ok = 1;
        #1;
        n_cmp++; if (outst_cnt !== 3'd4) begin n_mis++; $display("FAIL full_cnt: got %0d want 4", outst_cnt); end
        n_cmp++; if (s_if.req !== 1'b0) begin n_mis++; $display("FAIL full_s_req: got %b want 0", s_if.req); end
        n_cmp++; if ({m0_if.addr_ok, m1_if.addr_ok} !== 2'b00) begin n_mis++; $display("FAIL full_addr_ok: got %b want 00", {m0_if.addr_ok, m1_if.addr_ok}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            s_if.data_ok = 1; s_if.rdata = rd[i];
            #1;
            n_cmp++; if ({m0_if.data_ok, m1_if.data_ok} !== (exp_id[i] ? 2'b01 : 2'b10)) begin n_mis++; $display("FAIL drain_data_ok%0d: got %b", i, {m0_if.data_ok, m1_if.data_ok}); end
            n_cmp++; if ((exp_id[i] ? m1_if.rdata : m0_if.rdata) !== rd[i]) begin n_mis++; $display("FAIL drain_rdata%0d: got %h want %h", i, exp_id[i] ? m1_if.rdata : m0_if.rdata, rd[i]); end
            n_cmp++; if ((exp_id[i] ? m0_if.rdata : m1_if.rdata) !== 32'h0) begin n_mis++; $display("FAIL drain_other_rdata%0d: got %h want 0", i, exp_id[i] ? m0_if.rdata : m1_if.rdata); end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (outst_cnt !== 3'd0) begin n_mis++; $display("FAIL drain_cnt: got %0d want 0", outst_cnt); end
        n_cmp++; if (err_unexp_rsp !== 1'b0) begin n_mis++; $display("FAIL drain_err: got %b want 0", err_unexp_rsp); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i % 2 == 1) m1_if.req = 1; else m0_if.req = 1;
            s_if.addr_ok = 1;
        end
        @(negedge clk);
        idle_inputs();
        m0_if.req = 1; m1_if.req = 1; s_if.addr_ok = 1;
        s_if.data_ok = 1; s_if.rdata = 32'h55;
        #1;
        n_cmp++; if (s_if.req !== 1'b0) begin n_mis++; $display("FAIL fp_s_req: got %b want 0", s_if.req); end
        n_cmp++; if (m0_if.data_ok !== 1'b1 || m0_if.rdata !== 32'h55) begin n_mis++; $display("FAIL fp_rsp: got ok=%b rdata=%h want ok=1 rdata=55", m0_if.data_ok, m0_if.rdata); end
        n_cmp++; if ({m0_if.addr_ok, m1_if.addr_ok} !== 2'b00) begin n_mis++; $display("FAIL fp_addr_ok: got %b want 00", {m0_if.addr_ok, m1_if.addr_ok}); end
        @(negedge clk);
        s_if.data_ok = 0;
        #1;
        n_cmp++; if (outst_cnt !== 3'd3) begin n_mis++; $display("FAIL fp_cnt3: got %0d want 3", outst_cnt); end
        n_cmp++; if ({s_if.req, m0_if.addr_ok, m1_if.addr_ok} !== 3'b101) begin n_mis++; $display("FAIL fp_accept: got %b want 101", {s_if.req, m0_if.addr_ok, m1_if.addr_ok}); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (outst_cnt !== 3'd4) begin n_mis++; $display("FAIL fp_cnt4: got %0d want 4", outst_cnt); end
    endtask

    task automatic test_unexp();
        do_reset();
        @(negedge clk);
        s_if.data_ok = 1; s_if.rdata = 32'hAA;
        #1;
        n_cmp++; if ({m0_if.data_ok, m1_if.data_ok} !== 2'b00) begin n_mis++; $display("FAIL unexp_data_ok: got %b want 00", {m0_if.data_ok, m1_if.data_ok}); end
        @(negedge clk);
        s_if.data_ok = 0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (err_unexp_rsp !== 1'b1) begin n_mis++; $display("FAIL unexp_err_sticky: got %b want 1", err_unexp_rsp); end
        do_reset();
        #1;
        n_cmp++; if (err_unexp_rsp !== 1'b0) begin n_mis++; $display("FAIL unexp_err_clr: got %b want 0", err_unexp_rsp); end
        // Accept and response racing into an empty FIFO: no bypass to the new owner.
        @(negedge clk);
        m0_if.req = 1; s_if.addr_ok = 1; s_if.data_ok = 1; s_if.rdata = 32'hBB;
        #1;
        n_cmp++; if ({m0_if.addr_ok, m0_if.data_ok} !== 2'b10) begin n_mis++; $display("FAIL race_ok: got %b want 10", {m0_if.addr_ok, m0_if.data_ok}); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if ({outst_cnt, err_unexp_rsp} !== {3'd1, 1'b1}) begin n_mis++; $display("FAIL race_state: got cnt=%0d err=%b want cnt=1 err=1", outst_cnt, err_unexp_rsp); end
    endtask

    task automatic test_write();
        do_reset();
        @(negedge clk);
        m1_if.req = 1; m1_if.wr = 1; m1_if.wstrb = 4'hF; m1_if.size = 2'd2;
        m1_if.addr = 32'h0000_0300; m1_if.wdata = 32'hDEAD_BEEF; s_if.addr_ok = 1;
        #1;
        n_cmp++; if ({s_if.wr, s_if.wstrb} !== 5'b1_1111) begin n_mis++; $display("FAIL wr_fields: got wr=%b wstrb=%h want 1 f", s_if.wr, s_if.wstrb); end
        n_cmp++; if (s_if.wdata !== 32'hDEAD_BEEF || s_if.addr !== 32'h0000_0300) begin n_mis++; $display("FAIL wr_data: got %h@%h want deadbeef@00000300", s_if.wdata, s_if.addr); end
        n_cmp++; if (m1_if.addr_ok !== 1'b1) begin n_mis++; $display("FAIL wr_addr_ok: got %b want 1", m1_if.addr_ok); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (outst_cnt !== 3'd1) begin n_mis++; $display("FAIL wr_cnt1: got %0d want 1", outst_cnt); end
        @(negedge clk);
        s_if.data_ok = 1;
        #1;
        n_cmp++; if ({m0_if.data_ok, m1_if.data_ok} !== 2'b01) begin n_mis++; $display("FAIL wr_data_ok: got %b want 01", {m0_if.data_ok, m1_if.data_ok}); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (outst_cnt !== 3'd0) begin n_mis++; $display("FAIL wr_cnt0: got %0d want 0", outst_cnt); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_fill_drain();
        test_full_pop();
        test_unexp();
        test_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
